// File: rtl/stepper_phase_decode_pkg.sv
// Shared definitions for the stepper coil-phase decoder: half-step table,
// channel state encoding and position saturation bounds.
package stepper_phase_decode_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_COAST = 2'd2
    } chan_state_t;

    localparam logic [3:0] COAST_PAT = 4'b0000;

    typedef struct packed {
        logic       legal;
        logic [2:0] idx;
    } phase_dec_t;

    // Position of a coil pattern around the 8-entry half-step ring.
    function automatic phase_dec_t decode_phase(input logic [3:0] pat);
        phase_dec_t d;
        d.legal = 1'b1;
        d.idx   = 3'd0;
        case (pat)
            4'b0001: d.idx = 3'd0;
            4'b0011: d.idx = 3'd1;
            4'b0010: d.idx = 3'd2;
            4'b0110: d.idx = 3'd3;
            4'b0100: d.idx = 3'd4;
            4'b1100: d.idx = 3'd5;
            4'b1000: d.idx = 3'd6;
            4'b1001: d.idx = 3'd7;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic int pos_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int pos_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/stepper_phase_decode_if.sv
// Coil-phase inputs and decoded position/status outputs of the decoder.
interface stepper_phase_decode_if #(
    parameter int POS_W = 11
);
    logic [3:0]              signal_x;
    logic [3:0]              signal_y;
    logic                    vsync;
    logic                    pos_clr;
    logic                    err_clr;
    logic signed [POS_W-1:0] pos_x;
    logic signed [POS_W-1:0] pos_y;
    logic                    step_x;
    logic                    step_y;
    logic                    dir_x;
    logic                    dir_y;
    logic                    locked_x;
    logic                    locked_y;
    logic                    err_x;
    logic                    err_y;

    modport master (
        output signal_x, signal_y, vsync, pos_clr, err_clr,
        input  pos_x, pos_y, step_x, step_y, dir_x, dir_y,
               locked_x, locked_y, err_x, err_y
    );

    modport slave (
        input  signal_x, signal_y, vsync, pos_clr, err_clr,
        output pos_x, pos_y, step_x, step_y, dir_x, dir_y,
               locked_x, locked_y, err_x, err_y
    );
endinterface

// File: rtl/stepper_phase_decode_chan.sv
// One axis: 2-FF synchronizer, stability filter, INIT/TRACK/COAST tracker
// and saturating signed half-step accumulator.
module stepper_phase_chan
    import stepper_phase_decode_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int POS_W         = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              phase,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic signed [POS_W-1:0] pos,
    output logic                    step,
    output logic                    dir,
    output logic                    locked,
    output logic                    err
);
    localparam logic [4:0] ACCEPT_CNT = 5'(FILTER_CYCLES);
    localparam int         POS_MAX    = pos_max(POS_W);
    localparam int         POS_MIN    = pos_min(POS_W);

    logic [3:0]  sync_meta, sync_pat;
    logic [4:0]  stable_cnt;
    logic        accept;
    chan_state_t state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic signed [POS_W-1:0] pos_nxt;
    logic        step_nxt, dir_nxt, err_nxt;
    phase_dec_t  dec;
    logic [2:0]  delta;
    logic        move_en;
    int          move, sum;

    // Counter sticks at ACCEPT_CNT+1 so a held pattern is accepted only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= '0;
            sync_pat   <= '0;
            stable_cnt <= '0;
        end else begin
            // NOTE: registers take <= so every flop samples pre-edge values; blocking here would collapse the synchronizer.
            sync_meta <= phase;
            sync_pat  <= sync_meta;
            if (sync_meta != sync_pat)
                stable_cnt <= '0;
            else if (stable_cnt <= ACCEPT_CNT)
                stable_cnt <= stable_cnt + 5'd1;
        end
    end

    assign accept = (stable_cnt == ACCEPT_CNT);
    assign dec    = decode_phase(sync_pat);
    assign delta  = dec.idx - idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
        state_nxt = state;
        idx_nxt   = idx;
        pos_nxt   = pos;
        dir_nxt   = dir;
        step_nxt  = 1'b0;
        err_nxt   = err_clr ? 1'b0 : err;
        move_en   = 1'b0;
        move      = 0;
        if (accept) begin
            if (sync_pat == COAST_PAT) begin
                if (state == ST_TRACK) state_nxt = ST_COAST;
            end else if (!dec.legal) begin
                err_nxt   = 1'b1;
                state_nxt = ST_INIT;
            end else if (state == ST_TRACK) begin
                idx_nxt = dec.idx;
                case (delta)
                    3'd0: ;
                    3'd1, 3'd2: begin move_en = 1'b1; move = int'(delta);     dir_nxt = 1'b1; end
                    3'd6, 3'd7: begin move_en = 1'b1; move = int'(delta) - 8; dir_nxt = 1'b0; end
                    // Half a cycle (or an odd jump) away: direction cannot be told.
                    default: begin err_nxt = 1'b1; state_nxt = ST_INIT; end
                endcase
            end else begin
                idx_nxt   = dec.idx;
                state_nxt = ST_TRACK;
            end
        end
        sum = int'(pos) + move;
        if (move_en) begin
            step_nxt = 1'b1;
            if (sum > POS_MAX) begin
                pos_nxt = POS_W'(POS_MAX);
                err_nxt = 1'b1;
            end else if (sum < POS_MIN) begin
                pos_nxt = POS_W'(POS_MIN);
                err_nxt = 1'b1;
            end else begin
                pos_nxt = POS_W'(sum);
            end
        end
        if (pos_clr) pos_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            pos  <= '0;
            step <= 1'b0;
            dir  <= 1'b0;
            err  <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            pos  <= pos_nxt;
            step <= step_nxt;
            dir  <= dir_nxt;
            err  <= err_nxt;
        end
    end

    assign locked = (state == ST_TRACK);

endmodule

// File: rtl/stepper_phase_decode.sv
// Two-axis stepper coil-phase decoder. Define STEP_DECODE_VSYNC_LATCH_EN to
// present pos_x/pos_y as copies latched on each synchronized vsync rise.
module stepper_phase_decode
    import stepper_phase_decode_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int POS_W         = 11
) (
    input logic                   CLK100MHZ,
    input logic                   reset,
    stepper_phase_decode_if.slave bus
);
    logic signed [POS_W-1:0] cnt_x, cnt_y;

    stepper_phase_chan #(.FILTER_CYCLES(FILTER_CYCLES), .POS_W(POS_W)) u_chan_x (
        .clk(CLK100MHZ), .rst_n(reset), .phase(bus.signal_x),
        .pos_clr(bus.pos_clr), .err_clr(bus.err_clr),
        .pos(cnt_x), .step(bus.step_x), .dir(bus.dir_x),
        .locked(bus.locked_x), .err(bus.err_x)
    );

    stepper_phase_chan #(.FILTER_CYCLES(FILTER_CYCLES), .POS_W(POS_W)) u_chan_y (
        .clk(CLK100MHZ), .rst_n(reset), .phase(bus.signal_y),
        .pos_clr(bus.pos_clr), .err_clr(bus.err_clr),
        .pos(cnt_y), .step(bus.step_y), .dir(bus.dir_y),
        .locked(bus.locked_y), .err(bus.err_y)
    );

`ifdef STEP_DECODE_VSYNC_LATCH_EN
    logic vs_meta, vs_sync, vs_prev, vs_rise_q;
    logic signed [POS_W-1:0] pos_x_q, pos_y_q;

    // Copy taken the cycle after the registered rise so a frame sees one stable value.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            vs_meta   <= 1'b0;
            vs_sync   <= 1'b0;
            vs_prev   <= 1'b0;
            vs_rise_q <= 1'b0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
        end else begin
            vs_meta   <= bus.vsync;
            vs_sync   <= vs_meta;
            vs_prev   <= vs_sync;
            vs_rise_q <= vs_sync & ~vs_prev;
            if (vs_rise_q) begin
                pos_x_q <= cnt_x;
                pos_y_q <= cnt_y;
            end
        end
    end

    assign bus.pos_x = pos_x_q;
    assign bus.pos_y = pos_y_q;
`else
    logic unused_vsync;
    assign unused_vsync = bus.vsync;
    assign bus.pos_x    = cnt_x;
    assign bus.pos_y    = cnt_y;
`endif

endmodule

// File: tb/tb_stepper_phase_decode.sv
// Bench for stepper_phase_decode: vector table, directed corner sequences and
// randomized coil patterns against a ring-position model.
module tb_stepper_phase_decode;
    localparam int FILTER_CYCLES = 4;
    localparam int POS_W         = 11;
    localparam int SETTLE        = FILTER_CYCLES + 4;
    localparam int POS_MAX       = 2 ** (POS_W - 1) - 1;
    localparam int POS_MIN       = -(2 ** (POS_W - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stepper_phase_decode_if #(.POS_W(POS_W)) bus ();

    stepper_phase_decode #(.FILTER_CYCLES(FILTER_CYCLES), .POS_W(POS_W)) dut (
        .CLK100MHZ(clk), .reset(rst_n), .bus(bus)
    );

    typedef struct {
        logic [3:0] pat;
        int         pos;
        int         dir;
        int         locked;
        int         err;
    } vec_t;

    int tests  = 0;
    int failed = 0;

    logic [3:0] phase_tab [8];
    logic [3:0] bad_tab   [7];
    int         dtab      [5];
    vec_t       vecs      [14];

    int         m_pos[2], m_ref[2], m_dir[2], m_err[2];
    bit         m_coast[2];
    logic [3:0] last_pat[2];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Makes the visible positions current when they are frame-latched.
    task automatic refresh_pos();
`ifdef STEP_DECODE_VSYNC_LATCH_EN
        bus.vsync = 1'b1;
        tick(6);
        bus.vsync = 1'b0;
        tick(3);
`endif
    endtask

    task automatic apply_x(input logic [3:0] pat);
        bus.signal_x = pat;
        tick(SETTLE);
    endtask

    function automatic int pos_x_i();
        return int'($signed(bus.pos_x));
    endfunction

    function automatic int pos_y_i();
        return int'($signed(bus.pos_y));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0; m_ref[c] = -1; m_dir[c] = 0; m_err[c] = 0;
            m_coast[c] = 1'b0; last_pat[c] = 4'b0000;
        end
    endtask

    // Ring-position model: a held pattern only counts once, when it first appears.
    task automatic model_apply(input int ch, input logic [3:0] pat, output bit stepped);
        int k, d, mv, p;
        stepped = 1'b0;
        if (pat == last_pat[ch]) return;
        last_pat[ch] = pat;
        k = -1;
        for (int i = 0; i < 8; i++) if (phase_tab[i] == pat) k = i;
        if (pat == 4'b0000) begin
            if (m_ref[ch] >= 0) m_coast[ch] = 1'b1;
        end else if (k < 0) begin
            m_err[ch] = 1; m_ref[ch] = -1; m_coast[ch] = 1'b0;
        end else if (m_ref[ch] < 0 || m_coast[ch]) begin
            m_ref[ch] = k; m_coast[ch] = 1'b0;
        end else begin
            d = (k - m_ref[ch] + 8) % 8;
            if (d == 0) begin
            end else if (d <= 2 || d >= 6) begin
                mv = (d <= 2) ? d : d - 8;
                p  = m_pos[ch] + mv;
                if (p > POS_MAX) begin p = POS_MAX; m_err[ch] = 1; end
                if (p < POS_MIN) begin p = POS_MIN; m_err[ch] = 1; end
                m_pos[ch] = p;
                m_dir[ch] = (d <= 2) ? 1 : 0;
                m_ref[ch] = k;
                stepped   = 1'b1;
            end else begin
                m_err[ch] = 1; m_ref[ch] = -1;
            end
        end
    endtask

    function automatic logic [3:0] pick(input int ch);
        int r, base;
        r    = $urandom_range(0, 15);
        base = (m_ref[ch] < 0 || m_coast[ch]) ? $urandom_range(0, 7) : m_ref[ch];
        if (r < 11)  return phase_tab[(base + dtab[$urandom_range(0, 4)]) % 8];
        if (r < 13)  return 4'b0000;
        if (r == 13) return phase_tab[(base + 4) % 8];
        return bad_tab[$urandom_range(0, 6)];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, pulses, idx, p0, cx, cy, hold;
        bit sx, sy;
        logic [3:0] nx, ny;

        phase_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
        bad_tab   = '{4'b0101, 4'b0111, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
        dtab      = '{0, 1, 2, 6, 7};
        vecs[0]  = '{4'b0001,  0, 0, 1, 0};
        vecs[1]  = '{4'b0011,  1, 1, 1, 0};
        vecs[2]  = '{4'b0110,  3, 1, 1, 0};
        vecs[3]  = '{4'b0010,  2, 0, 1, 0};
        vecs[4]  = '{4'b0001,  0, 0, 1, 0};
        vecs[5]  = '{4'b1001, -1, 0, 1, 0};
        vecs[6]  = '{4'b0001,  0, 1, 1, 0};
        vecs[7]  = '{4'b0000,  0, 1, 0, 0};
        vecs[8]  = '{4'b0100,  0, 1, 1, 0};
        vecs[9]  = '{4'b1100,  1, 1, 1, 0};
        vecs[10] = '{4'b1000,  2, 1, 1, 0};
        vecs[11] = '{4'b0010,  2, 1, 0, 1};
        vecs[12] = '{4'b0011,  2, 1, 1, 1};
        vecs[13] = '{4'b0111,  2, 1, 0, 1};

        bus.signal_x = 4'b0000; bus.signal_y = 4'b0000;
        bus.vsync = 1'b0; bus.pos_clr = 1'b0; bus.err_clr = 1'b0;

        tick(2);
        check("reset pos_x", pos_x_i(), 0);
        check("reset step_x", int'(bus.step_x), 0);
        check("reset dir_x", int'(bus.dir_x), 0);
        check("reset locked_x", int'(bus.locked_x), 0);
        check("reset err_x", int'(bus.err_x), 0);
        rst_n = 1'b1;
        tick(1);

        // Vector table on x; y stays idle throughout.
        for (int i = 0; i < 14; i++) begin
            apply_x(vecs[i].pat);
            refresh_pos();
            check($sformatf("vec%0d pos_x", i), pos_x_i(), vecs[i].pos);
            check($sformatf("vec%0d dir_x", i), int'(bus.dir_x), vecs[i].dir);
            check($sformatf("vec%0d locked_x", i), int'(bus.locked_x), vecs[i].locked);
            check($sformatf("vec%0d err_x", i), int'(bus.err_x), vecs[i].err);
        end
        check("idle locked_y", int'(bus.locked_y), 0);
        check("idle pos_y", pos_y_i(), 0);

        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        check("err_clr clears", int'(bus.err_x), 0);
        bus.signal_x = 4'b1111;
        tick(FILTER_CYCLES + 2);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        check("err_clr vs new fault", int'(bus.err_x), 1);

        // Latency of the first counted step.
        do_reset();
        apply_x(4'b0001);
        check("first accept locked_x", int'(bus.locked_x), 1);
        bus.signal_x = 4'b0011;
        first = 0; pulses = 0;
        for (int e = 1; e <= FILTER_CYCLES + 6; e++) begin
            tick(1);
            if (bus.step_x) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        check("step latency edges", first, FILTER_CYCLES + 3);
        check("step pulse count", pulses, 1);
        refresh_pos();
        check("latency pos_x", pos_x_i(), 1);
        check("latency dir_x", int'(bus.dir_x), 1);

        // Reset in the middle of the filter window drops the pending step.
        bus.signal_x = 4'b0010;
        tick(3);
        do_reset();
        pulses = 0;
        for (int e = 0; e < SETTLE; e++) begin tick(1); pulses += int'(bus.step_x); end
        refresh_pos();
        check("mid-filter reset steps", pulses, 0);
        check("mid-filter reset pos_x", pos_x_i(), 0);

        // 16 forward then 20 backward through the wrap.
        do_reset();
        idx = 0;
        apply_x(phase_tab[0]);
        for (int i = 0; i < 16; i++) begin idx = (idx + 1) % 8; apply_x(phase_tab[idx]); end
        for (int i = 0; i < 20; i++) begin idx = (idx + 7) % 8; apply_x(phase_tab[idx]); end
        refresh_pos();
        check("fwd/back pos_x", pos_x_i(), -4);
        check("fwd/back dir_x", int'(bus.dir_x), 0);
        check("fwd/back err_x", int'(bus.err_x), 0);

        // Short glitch is filtered; then a half-cycle jump faults.
        do_reset();
        apply_x(4'b0001);
        apply_x(4'b0011);
        bus.signal_x = 4'b0110; tick(2); bus.signal_x = 4'b0011;
        pulses = 0;
        for (int e = 0; e < SETTLE + 2; e++) begin tick(1); pulses += int'(bus.step_x); end
        refresh_pos();
        check("glitch steps", pulses, 0);
        check("glitch pos_x", pos_x_i(), 1);
        apply_x(4'b0001);
        apply_x(4'b0100);
        refresh_pos();
        check("delta4 err_x", int'(bus.err_x), 1);
        check("delta4 locked_x", int'(bus.locked_x), 0);
        check("delta4 pos_x", pos_x_i(), 0);

        // Coast then relock without counting.
        do_reset();
        apply_x(4'b0001);
        apply_x(4'b0011);
        bus.signal_x = 4'b0000; tick(10);
        check("coast locked_x", int'(bus.locked_x), 0);
        apply_x(4'b0100);
        refresh_pos();
        check("relock locked_x", int'(bus.locked_x), 1);
        check("relock pos_x", pos_x_i(), 1);
        apply_x(4'b1100);
        refresh_pos();
        check("after relock pos_x", pos_x_i(), 2);

        // Positive saturation, then pos_clr racing a step, then negative saturation.
        do_reset();
        apply_x(phase_tab[0]);
        for (int i = 1; i <= 1023; i++) apply_x(phase_tab[i % 8]);
        refresh_pos();
        check("near max pos_x", pos_x_i(), POS_MAX);
        check("near max err_x", int'(bus.err_x), 0);
        bus.signal_x = phase_tab[0];
        pulses = 0;
        for (int e = 0; e < SETTLE; e++) begin tick(1); pulses += int'(bus.step_x); end
        refresh_pos();
        check("clamp pos_x", pos_x_i(), POS_MAX);
        check("clamp err_x", int'(bus.err_x), 1);
        check("clamp step pulse", pulses, 1);
        bus.signal_x = phase_tab[1];
        tick(FILTER_CYCLES + 2);
        bus.pos_clr = 1'b1; tick(1); bus.pos_clr = 1'b0;
        check("pos_clr step_x", int'(bus.step_x), 1);
        tick(2);
        refresh_pos();
        check("pos_clr pos_x", pos_x_i(), 0);
        bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
        idx = 1;
        for (int i = 0; i < 1024; i++) begin idx = (idx + 7) % 8; apply_x(phase_tab[idx]); end
        refresh_pos();
        check("near min pos_x", pos_x_i(), POS_MIN);
        check("near min err_x", int'(bus.err_x), 0);
        idx = (idx + 7) % 8;
        apply_x(phase_tab[idx]);
        refresh_pos();
        check("clamp min pos_x", pos_x_i(), POS_MIN);
        check("clamp min err_x", int'(bus.err_x), 1);

`ifdef STEP_DECODE_VSYNC_LATCH_EN
        do_reset();
        apply_x(4'b0001);
        apply_x(4'b0011);
        check("frame hold pos_x", pos_x_i(), 0);
        bus.vsync = 1'b1;
        first = 0;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            if (first == 0 && pos_x_i() != 0) first = e;
        end
        bus.vsync = 1'b0;
        check("vsync latch edge", first, 4);
        check("vsync latch pos_x", pos_x_i(), 1);
`endif

        // Randomized patterns on both axes against the model.
        do_reset();
        model_reset();
        for (int it = 0; it < 200; it++) begin
            nx = pick(0);
            ny = pick(1);
            if (m_err[0] != 0 || m_err[1] != 0) begin
                bus.err_clr = 1'b1;
                m_err[0] = 0; m_err[1] = 0;
            end
            bus.signal_x = nx;
            bus.signal_y = ny;
            model_apply(0, nx, sx);
            model_apply(1, ny, sy);
            hold = SETTLE + $urandom_range(0, 2);
            cx = 0; cy = 0;
            for (int c = 0; c < hold; c++) begin
                tick(1);
                bus.err_clr = 1'b0;
                cx += int'(bus.step_x);
                cy += int'(bus.step_y);
            end
            refresh_pos();
            check($sformatf("rnd%0d pos_x", it), pos_x_i(), m_pos[0]);
            check($sformatf("rnd%0d pos_y", it), pos_y_i(), m_pos[1]);
            check($sformatf("rnd%0d dir_x", it), int'(bus.dir_x), m_dir[0]);
            check($sformatf("rnd%0d dir_y", it), int'(bus.dir_y), m_dir[1]);
            check($sformatf("rnd%0d err_x", it), int'(bus.err_x), m_err[0]);
            check($sformatf("rnd%0d err_y", it), int'(bus.err_y), m_err[1]);
            check($sformatf("rnd%0d locked_x", it), int'(bus.locked_x),
                  (m_ref[0] >= 0 && !m_coast[0]) ? 1 : 0);
            check($sformatf("rnd%0d locked_y", it), int'(bus.locked_y),
                  (m_ref[1] >= 0 && !m_coast[1]) ? 1 : 0);
            check($sformatf("rnd%0d steps_x", it), cx, sx ? 1 : 0);
            check($sformatf("rnd%0d steps_y", it), cy, sy ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
